// File: rtl/sprite_render_engine.sv
`default_nettype none
// ============================================================================
// Module  : sprite_render_engine
// Brief   : Per-frame erase / move / redraw of N sprites through a pixel port.
// Revision: 1.0  initial release
// ============================================================================
module sprite_render_engine #(
    parameter int         N_SPR     = 2,
    parameter int         SPR_W     = 4,
    parameter int         SPR_H     = 4,
    parameter int         SCR_W     = 160,
    parameter int         SCR_H     = 120,
    parameter logic [2:0] BG_COLOUR = 3'b111,
    parameter bit         WRAP      = 1'b0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 tick_i,
    input  logic [8*N_SPR-1:0]   init_x_i,
    input  logic [7*N_SPR-1:0]   init_y_i,
    input  logic [4*N_SPR-1:0]   dir_i,
    input  logic [3*N_SPR-1:0]   colour_a_i,
    input  logic [3*N_SPR-1:0]   colour_b_i,
    input  logic [N_SPR-1:0]     pattern_i,
    output logic                 busy_o,
    output logic [7:0]           vga_x_o,
    output logic [6:0]           vga_y_o,
    output logic [2:0]           vga_colour_o,
    output logic                 vga_we_o,
    output logic [8*N_SPR-1:0]   pos_x_o,
    output logic [7*N_SPR-1:0]   pos_y_o
);

    localparam int OXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int OYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int IW  = (N_SPR > 1) ? $clog2(N_SPR) : 1;

    localparam logic [7:0]     X_MAX    = 8'(SCR_W - SPR_W);
    localparam logic [6:0]     Y_MAX    = 7'(SCR_H - SPR_H);
    localparam logic [OXW-1:0] OX_LAST  = OXW'(SPR_W - 1);
    localparam logic [OYW-1:0] OY_LAST  = OYW'(SPR_H - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(N_SPR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ERASE = 2'd1,
        S_MOVE  = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   idx_q;
    logic [OXW-1:0]  ox_q;
    logic [OYW-1:0]  oy_q;
    logic [7:0]      pos_x_q [N_SPR];
    logic [6:0]      pos_y_q [N_SPR];
    logic            busy_q;
    logic            we_q;
    logic [7:0]      vx_q;
    logic [6:0]      vy_q;
    logic [2:0]      col_q;

    logic            w_last;
    logic [OXW-1:0]  w_ox_d;
    logic [OYW-1:0]  w_oy_d;
    logic [IW-1:0]   w_idx_inc;
    logic [7:0]      w_cur_x;
    logic [6:0]      w_cur_y;
    logic [3:0]      w_dir;
    logic [2:0]      w_col_a;
    logic [2:0]      w_col_b;
    logic            w_pat;
    logic [2:0]      w_draw_col_d;
    logic [7:0]      w_x_d;
    logic [6:0]      w_y_d;

    always_comb begin
        w_last    = (ox_q == OX_LAST) && (oy_q == OY_LAST);
        w_ox_d    = (ox_q == OX_LAST) ? '0 : ox_q + 1'b1;
        w_oy_d    = (ox_q == OX_LAST) ? oy_q + 1'b1 : oy_q;
        w_idx_inc = idx_q + 1'b1;
        w_cur_x   = pos_x_q[idx_q];
        w_cur_y   = pos_y_q[idx_q];
        w_dir     = dir_i[4*idx_q +: 4];
        w_col_a   = colour_a_i[3*idx_q +: 3];
        w_col_b   = colour_b_i[3*idx_q +: 3];
        w_pat     = pattern_i[idx_q];
        // Checker colour is chosen for the offset about to be registered.
        w_draw_col_d = (w_pat && (w_ox_d[0] ^ w_oy_d[0])) ? w_col_b : w_col_a;

        // Opposing direction bits cancel; each axis moves at most one pixel.
        w_x_d = w_cur_x;
        if (w_dir[0] && !w_dir[3]) begin
            if (w_cur_x >= X_MAX) w_x_d = WRAP ? 8'd0 : X_MAX;
            else                  w_x_d = w_cur_x + 8'd1;
        end else if (w_dir[3] && !w_dir[0]) begin
            if (w_cur_x == 8'd0)  w_x_d = WRAP ? X_MAX : 8'd0;
            else                  w_x_d = w_cur_x - 8'd1;
        end

        w_y_d = w_cur_y;
        if (w_dir[2] && !w_dir[1]) begin
            if (w_cur_y >= Y_MAX) w_y_d = WRAP ? 7'd0 : Y_MAX;
            else                  w_y_d = w_cur_y + 7'd1;
        end else if (w_dir[1] && !w_dir[2]) begin
            if (w_cur_y == 7'd0)  w_y_d = WRAP ? Y_MAX : 7'd0;
            else                  w_y_d = w_cur_y - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            col_q   <= '0;
            for (int i = 0; i < N_SPR; i++) begin
                pos_x_q[i] <= init_x_i[8*i +: 8];
                pos_y_q[i] <= init_y_i[7*i +: 7];
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tick_i) begin
                        state_q <= S_ERASE;
                        busy_q  <= 1'b1;
                        idx_q   <= '0;
                        ox_q    <= '0;
                        oy_q    <= '0;
                        we_q    <= 1'b1;
                        vx_q    <= pos_x_q[0];
                        vy_q    <= pos_y_q[0];
                        col_q   <= BG_COLOUR;
                    end
                end
                S_ERASE: begin
                    if (w_last) begin
                        state_q <= S_MOVE;
                        we_q    <= 1'b0;
                        ox_q    <= '0;
                        oy_q    <= '0;
                    end else begin
                        ox_q  <= w_ox_d;
                        oy_q  <= w_oy_d;
                        vx_q  <= w_cur_x + 8'(w_ox_d);
                        vy_q  <= w_cur_y + 7'(w_oy_d);
                        col_q <= BG_COLOUR;
                    end
                end
                S_MOVE: begin
                    // The first draw pixel already uses the stepped position.
                    pos_x_q[idx_q] <= w_x_d;
                    pos_y_q[idx_q] <= w_y_d;
                    state_q <= S_DRAW;
                    we_q    <= 1'b1;
                    vx_q    <= w_x_d;
                    vy_q    <= w_y_d;
                    col_q   <= w_col_a;
                end
                S_DRAW: begin
                    if (w_last) begin
                        ox_q <= '0;
                        oy_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            we_q    <= 1'b0;
                        end else begin
                            state_q <= S_ERASE;
                            idx_q   <= w_idx_inc;
                            we_q    <= 1'b1;
                            vx_q    <= pos_x_q[w_idx_inc];
                            vy_q    <= pos_y_q[w_idx_inc];
                            col_q   <= BG_COLOUR;
                        end
                    end else begin
                        ox_q  <= w_ox_d;
                        oy_q  <= w_oy_d;
                        vx_q  <= w_cur_x + 8'(w_ox_d);
                        vy_q  <= w_cur_y + 7'(w_oy_d);
                        col_q <= w_draw_col_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign vga_we_o     = we_q;
    assign vga_x_o      = vx_q;
    assign vga_y_o      = vy_q;
    assign vga_colour_o = col_q;

    for (genvar i = 0; i < N_SPR; i++) begin : g_pos
        assign pos_x_o[8*i +: 8] = pos_x_q[i];
        assign pos_y_o[7*i +: 7] = pos_y_q[i];
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_render_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_sprite_render_engine
// Brief   : Clamp and wrap engines side by side against a pass-level model.
// Revision: 1.0  initial release
// ============================================================================
module tb_sprite_render_engine;

    localparam int         N    = 2;
    localparam int         W    = 4;
    localparam int         H    = 4;
    localparam int         XMAX = 156;
    localparam int         YMAX = 116;
    localparam logic [2:0] BG   = 3'b111;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] init_x;
    logic [13:0] init_y;
    logic [7:0]  dir;
    logic [5:0]  ca;
    logic [5:0]  cb;
    logic [1:0]  pat;

    logic        busy0, we0, busy1, we1;
    logic [7:0]  vx0, vx1;
    logic [6:0]  vy0, vy1;
    logic [2:0]  vc0, vc1;
    logic [15:0] px0, px1;
    logic [13:0] py0, py1;

    always #5 clk = ~clk;

    sprite_render_engine #(.WRAP(1'b0)) u_clamp (
        .clk(clk), .resetn(resetn), .tick_i(tick),
        .init_x_i(init_x), .init_y_i(init_y), .dir_i(dir),
        .colour_a_i(ca), .colour_b_i(cb), .pattern_i(pat),
        .busy_o(busy0), .vga_x_o(vx0), .vga_y_o(vy0), .vga_colour_o(vc0),
        .vga_we_o(we0), .pos_x_o(px0), .pos_y_o(py0)
    );

    sprite_render_engine #(.WRAP(1'b1)) u_wrap (
        .clk(clk), .resetn(resetn), .tick_i(tick),
        .init_x_i(init_x), .init_y_i(init_y), .dir_i(dir),
        .colour_a_i(ca), .colour_b_i(cb), .pattern_i(pat),
        .busy_o(busy1), .vga_x_o(vx1), .vga_y_o(vy1), .vga_colour_o(vc1),
        .vga_we_o(we1), .pos_x_o(px1), .pos_y_o(py1)
    );

    typedef struct {
        bit         busy;
        bit         we;
        bit         rst;
        logic [2:0] col;
        int         x0;
        int         y0;
        int         x1;
        int         y1;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    bit         started = 1'b0;
    int         mx[2][N];
    int         my[2][N];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         busy_cyc = 0;
    logic [2:0] scr[160][120];

    function automatic void chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Sprite moves at most one pixel per axis; d=1 models the wrapping engine.
    task automatic step(input int d, input int s);
        int nx, ny;
        nx = mx[d][s] + int'(dir[4*s]) - int'(dir[4*s+3]);
        ny = my[d][s] + int'(dir[4*s+2]) - int'(dir[4*s+1]);
        if (d == 1) begin
            if (nx > XMAX) nx = 0; else if (nx < 0) nx = XMAX;
            if (ny > YMAX) ny = 0; else if (ny < 0) ny = YMAX;
        end else begin
            if (nx > XMAX) nx = XMAX; else if (nx < 0) nx = 0;
            if (ny > YMAX) ny = YMAX; else if (ny < 0) ny = 0;
        end
        mx[d][s] = nx;
        my[d][s] = ny;
    endtask

    task automatic push_box(input int s, input bit draw);
        exp_t e;
        for (int p = 0; p < W*H; p++) begin
            e.busy = 1'b1;
            e.we   = 1'b1;
            e.rst  = 1'b0;
            e.x0   = mx[0][s] + p % W;
            e.y0   = my[0][s] + p / W;
            e.x1   = mx[1][s] + p % W;
            e.y1   = my[1][s] + p / W;
            if (!draw)
                e.col = BG;
            else if (pat[s] && (((p % W) ^ (p / W)) & 1) == 1)
                e.col = cb[3*s +: 3];
            else
                e.col = ca[3*s +: 3];
            q.push_back(e);
        end
    endtask

    task automatic build_pass();
        exp_t e;
        for (int s = 0; s < N; s++) begin
            push_box(s, 1'b0);
            e.busy = 1'b1; e.we = 1'b0; e.rst = 1'b0; e.col = '0;
            e.x0 = 0; e.y0 = 0; e.x1 = 0; e.y1 = 0;
            q.push_back(e);
            step(0, s);
            step(1, s);
            push_box(s, 1'b1);
        end
    endtask

    // cur describes the outputs expected during the cycle after this edge.
    always @(posedge clk) begin
        if (!resetn) begin
            q.delete();
            for (int s = 0; s < N; s++) begin
                for (int d = 0; d < 2; d++) begin
                    mx[d][s] = int'(init_x[8*s +: 8]);
                    my[d][s] = int'(init_y[7*s +: 7]);
                end
            end
            cur.busy = 1'b0; cur.we = 1'b0; cur.rst = 1'b1; cur.col = '0;
            started  = 1'b1;
        end else begin
            if (q.size() == 0 && !cur.busy && tick) build_pass();
            if (q.size() > 0) cur = q.pop_front();
            else begin
                cur.busy = 1'b0; cur.we = 1'b0; cur.rst = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy_clamp", busy0, cur.busy);
            chk("busy_wrap", busy1, cur.busy);
            chk("we_clamp", we0, cur.we);
            chk("we_wrap", we1, cur.we);
            if (cur.we) begin
                chk("x_clamp", vx0, cur.x0);
                chk("y_clamp", vy0, cur.y0);
                chk("col_clamp", vc0, cur.col);
                chk("x_wrap", vx1, cur.x1);
                chk("y_wrap", vy1, cur.y1);
                chk("col_wrap", vc1, cur.col);
            end
            if (cur.rst) begin
                chk("rst_x", vx0, 0);
                chk("rst_y", vy0, 0);
                chk("rst_col", vc0, 0);
                chk("rst_x_wrap", vx1, 0);
            end
            if (!cur.busy) begin
                for (int s = 0; s < N; s++) begin
                    chk("posx_clamp", px0[8*s +: 8], mx[0][s]);
                    chk("posy_clamp", py0[7*s +: 7], my[0][s]);
                    chk("posx_wrap", px1[8*s +: 8], mx[1][s]);
                    chk("posy_wrap", py1[7*s +: 7], my[1][s]);
                end
            end
        end
        if (busy0) busy_cyc++;
        if (we0 && vx0 < 160 && vy0 < 120) scr[vx0][vy0] = vc0;
    end

    task automatic do_reset();
        @(posedge clk); #1 resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((cur.busy || q.size() > 0) && t < 300);
        if (t >= 300) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", t);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        init_x = {8'd50, 8'd10};
        init_y = {7'd60, 7'd20};
        dir    = 8'h00;
        ca     = {3'b001, 3'b010};
        cb     = 6'b000000;
        pat    = 2'b00;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("lit_reset_busy", busy0, 0);
        chk("lit_reset_we", we0, 0);
        chk("lit_reset_posx", px0[7:0], 10);

        // Stationary pass: erase and redraw the same boxes.
        busy_cyc = 0;
        pulse_tick();
        wait_idle();
        chk("lit_pass_len", busy_cyc, 66);
        chk("lit_draw_10_20", scr[10][20], 3'b010);
        chk("lit_draw_13_23", scr[13][23], 3'b010);
        chk("lit_draw_spr1", scr[53][63], 3'b001);

        // Step right, then opposing bits cancel.
        dir = 8'h01;
        pulse_tick();
        wait_idle();
        chk("lit_right_posx", px0[7:0], 11);
        chk("lit_right_edge", scr[14][20], 3'b010);
        chk("lit_right_erased", scr[10][20], 3'b111);
        dir = 8'h09;
        pulse_tick();
        wait_idle();
        chk("lit_rl_posx", px0[7:0], 11);

        // Corner: clamp holds, wrap jumps to the opposite edge.
        init_x[7:0] = 8'd156;
        init_y[6:0] = 7'd0;
        dir = 8'h03;
        do_reset();
        pulse_tick();
        wait_idle();
        chk("lit_clamp_x", px0[7:0], 156);
        chk("lit_clamp_y", py0[6:0], 0);
        chk("lit_wrap_x", px1[7:0], 0);
        chk("lit_wrap_y", py1[6:0], 116);

        // Checker colouring at the origin.
        init_x[7:0] = 8'd0;
        init_y[6:0] = 7'd0;
        dir = 8'h00;
        ca[2:0] = 3'b100;
        cb[2:0] = 3'b010;
        pat = 2'b01;
        do_reset();
        pulse_tick();
        wait_idle();
        chk("lit_chk_0_0", scr[0][0], 3'b100);
        chk("lit_chk_1_0", scr[1][0], 3'b010);
        chk("lit_chk_1_1", scr[1][1], 3'b100);
        chk("lit_chk_0_1", scr[0][1], 3'b010);

        // A tick while busy is dropped.
        dir = 8'h01;
        busy_cyc = 0;
        pulse_tick();
        repeat (10) @(posedge clk);
        pulse_tick();
        wait_idle();
        chk("lit_one_pass", busy_cyc, 66);
        repeat (20) @(negedge clk);
        chk("lit_no_queue", busy_cyc, 66);
        chk("lit_moved_posx", px0[7:0], 1);

        // Reset in the middle of sprite 0's draw phase.
        pulse_tick();
        repeat (20) @(posedge clk);
        #2 chk("lit_pre_rst_posx", px0[7:0], 2);
        chk("lit_pre_rst_we", we0, 1);
        resetn = 1'b0;
        @(posedge clk);
        #2 chk("lit_rst_we", we0, 0);
        chk("lit_rst_busy", busy0, 0);
        chk("lit_rst_posx", px0[7:0], 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
